// File: rtl/agri_pkg.sv
// Shared constants, channel indices and a width helper for the sensor_debounce block.
// Used by all sensor_debounce files; the optional chatter detector is enabled by SENSOR_FAULT_EN.
package agri_pkg;

  localparam int N_CH_DEF      = 7;
  localparam int PRESC_DEF     = 8;
  localparam int DB_CNT_DEF    = 4;
  localparam int FAULT_LIM_DEF = 8;

  typedef enum int {
    CH_I1 = 0,
    CH_I2 = 1,
    CH_I3 = 2,
    CH_I4 = 3,
    CH_I5 = 4,
    CH_I6 = 5,
    CH_I7 = 6
  } ch_idx_e;

  // Counter width for a value range 0..v-1, never narrower than one bit.
  function automatic int cw(input int v);
    return (v <= 1) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/sensor_debounce_if.sv
// Sensor-side bundle of sensor_debounce: sampling controls in, debounced levels and flags out.
// Fault is only driven non-zero when built with SENSOR_FAULT_EN.
interface sensor_debounce_if
  import agri_pkg::*;
#(
  parameter int N_CH = N_CH_DEF
);

  logic            En;
  logic [N_CH-1:0] Raw;
  logic            FaultClr;
  logic [N_CH-1:0] I;
  logic [N_CH-1:0] Chg;
  logic            Tick;
  logic [N_CH-1:0] Fault;

  modport master (output En, Raw, FaultClr, input I, Chg, Tick, Fault);
  modport slave  (input En, Raw, FaultClr, output I, Chg, Tick, Fault);

endinterface

// File: rtl/db_channel.sv
// One sensor channel: two-flop synchronizer, tick-driven debounce counter, level/change flops,
// and (with SENSOR_FAULT_EN) a sticky chatter detector counting aborted debounce attempts.
module db_channel
  import agri_pkg::*;
#(
  parameter int DB_CNT    = DB_CNT_DEF,
  parameter int FAULT_LIM = FAULT_LIM_DEF
) (
  input  logic Ck,
  input  logic Clr,
  input  logic i_raw,
  input  logic i_tick,
  input  logic i_fault_clr,
  output logic o_i,
  output logic o_chg,
  output logic o_fault
);

  localparam int CW = cw(DB_CNT + 1);
  localparam logic [CW-1:0] C_LAST = CW'(DB_CNT - 1);

  logic          r_s1;
  logic          r_s2;
  logic          r_i;
  logic          r_chg;
  logic [CW-1:0] r_c;
  logic          w_diff;
  logic          w_accept;

  assign w_diff   = r_s2 ^ r_i;
  assign w_accept = i_tick & w_diff & (r_c == C_LAST);

  always_ff @(posedge Ck or posedge Clr) begin
    if (Clr) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= i_raw;
      r_s2 <= r_s1;
    end
  end

  // Any agreeing tick before acceptance throws away the partial count.
  always_ff @(posedge Ck or posedge Clr) begin
    if (Clr) begin
      r_c   <= {CW{1'b0}};
      r_i   <= 1'b0;
      r_chg <= 1'b0;
    end else begin
      r_chg <= w_accept;
      if (i_tick) begin
        if (!w_diff) begin
          r_c <= {CW{1'b0}};
        end else if (r_c == C_LAST) begin
          r_c <= {CW{1'b0}};
          r_i <= r_s2;
        end else begin
          r_c <= r_c + CW'(1);
        end
      end
    end
  end

  assign o_i   = r_i;
  assign o_chg = r_chg;

`ifdef SENSOR_FAULT_EN
  localparam int KW = cw(FAULT_LIM + 1);
  localparam logic [KW-1:0] K_LIM = KW'(FAULT_LIM);

  logic [KW-1:0] r_k;
  logic          r_fault;
  logic          w_abort;
  logic [KW-1:0] w_k_inc;

  assign w_abort = i_tick & ~w_diff & (r_c != {CW{1'b0}});
  assign w_k_inc = (r_k == K_LIM) ? r_k : r_k + KW'(1);

  // Clear has priority over a coincident abort that would set the flag.
  always_ff @(posedge Ck or posedge Clr) begin
    if (Clr) begin
      r_k     <= {KW{1'b0}};
      r_fault <= 1'b0;
    end else if (i_fault_clr) begin
      r_k     <= {KW{1'b0}};
      r_fault <= 1'b0;
    end else if (w_accept) begin
      r_k <= {KW{1'b0}};
    end else if (w_abort) begin
      r_k <= w_k_inc;
      if (w_k_inc == K_LIM) begin
        r_fault <= 1'b1;
      end
    end
  end

  assign o_fault = r_fault;
`else
  logic w_unused_fclr;
  assign w_unused_fclr = i_fault_clr ^ (FAULT_LIM == 0);
  assign o_fault       = 1'b0;
`endif

endmodule

// File: rtl/sensor_debounce.sv
// Sensor input conditioning: shared sample prescaler feeding N_CH independent debounce channels.
// Define SENSOR_FAULT_EN to build the per-channel chatter (Fault) detectors.
module sensor_debounce
  import agri_pkg::*;
#(
  parameter int N_CH      = N_CH_DEF,
  parameter int PRESC     = PRESC_DEF,
  parameter int DB_CNT    = DB_CNT_DEF,
  parameter int FAULT_LIM = FAULT_LIM_DEF
) (
  input logic               Ck,
  input logic               Clr,
  sensor_debounce_if.slave  bus
);

  localparam int PW = cw(PRESC);
  localparam logic [PW-1:0] P_LAST = PW'(PRESC - 1);

  logic [PW-1:0]   r_p;
  logic            w_tick;
  logic [N_CH-1:0] w_i;
  logic [N_CH-1:0] w_chg;
  logic [N_CH-1:0] w_fault;

  // Tick is suppressed while reset is held so the strobe reads 0 during reset.
  assign w_tick = bus.En & (r_p == P_LAST) & ~Clr;

  always_ff @(posedge Ck or posedge Clr) begin
    if (Clr) begin
      r_p <= {PW{1'b0}};
    end else if (w_tick) begin
      r_p <= {PW{1'b0}};
    end else if (bus.En) begin
      r_p <= r_p + PW'(1);
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    db_channel #(
      .DB_CNT   (DB_CNT),
      .FAULT_LIM(FAULT_LIM)
    ) u_ch (
      .Ck         (Ck),
      .Clr        (Clr),
      .i_raw      (bus.Raw[g]),
      .i_tick     (w_tick),
      .i_fault_clr(bus.FaultClr),
      .o_i        (w_i[g]),
      .o_chg      (w_chg[g]),
      .o_fault    (w_fault[g])
    );
  end

  assign bus.I     = w_i;
  assign bus.Chg   = w_chg;
  assign bus.Fault = w_fault;
  assign bus.Tick  = w_tick;

endmodule

// File: tb/tb_sensor_debounce.sv
// Directed bench for sensor_debounce: PRESC=1 instance driven from a vector table plus
// chatter/reset sequences, and a PRESC=8 instance for tick timing and En hold.
module tb_sensor_debounce;
  import agri_pkg::*;

`ifdef SENSOR_FAULT_EN
  localparam bit FEAT = 1'b1;
`else
  localparam bit FEAT = 1'b0;
`endif

  logic ck;
  logic clr_a;
  logic clr_b;
  int   nvec;
  int   nfail;
  logic [6:0] m_i3;
  logic [6:0] m_i7;

  sensor_debounce_if #(.N_CH(7)) ifa ();
  sensor_debounce_if #(.N_CH(7)) ifb ();

  sensor_debounce #(.N_CH(7), .PRESC(1), .DB_CNT(4), .FAULT_LIM(8)) u_dut_a (
    .Ck(ck), .Clr(clr_a), .bus(ifa)
  );
  sensor_debounce #(.N_CH(7), .PRESC(8), .DB_CNT(4), .FAULT_LIM(8)) u_dut_b (
    .Ck(ck), .Clr(clr_b), .bus(ifb)
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  typedef struct packed {
    logic       clr;
    logic       en;
    logic [6:0] raw;
    logic [6:0] ei;
    logic [6:0] ec;
    logic       et;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input int n, input logic clr, input logic en, input logic [6:0] raw,
                     input logic [6:0] ei, input logic [6:0] ec, input logic et);
    repeat (n) tbl.push_back('{clr, en, raw, ei, ec, et});
  endtask

  task automatic check(input string nm, input int idx, input logic [6:0] act, input logic [6:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s #%0d: got %h, expected %h", nm, idx, act, exp);
    end
  endtask

  task automatic run_table();
    foreach (tbl[n]) begin
      @(negedge ck);
      clr_a    = tbl[n].clr;
      ifa.En   = tbl[n].en;
      ifa.Raw  = tbl[n].raw;
      @(posedge ck);
      #1;
      check("tbl_I", n, ifa.I, tbl[n].ei);
      check("tbl_Chg", n, ifa.Chg, tbl[n].ec);
      check("tbl_Tick", n, {6'd0, ifa.Tick}, {6'd0, tbl[n].et});
      check("tbl_Fault", n, ifa.Fault, 7'h00);
    end
  endtask

  // Raw[6] toggles 2-high/2-low: aborts land every 4th edge, the 8th on edge 32.
  task automatic run_chatter();
    @(negedge ck);
    clr_a = 1'b1; ifa.En = 1'b1; ifa.Raw = 7'h00; ifa.FaultClr = 1'b0;
    @(negedge ck);
    clr_a = 1'b0;
    for (int j = 0; j < 42; j++) begin
      ifa.Raw      = (j < 40 && (j % 4) < 2) ? m_i7 : 7'h00;
      ifa.FaultClr = (j == 40);
      @(posedge ck);
      #1;
      check("chat_I", j, ifa.I, 7'h00);
      check("chat_Chg", j, ifa.Chg, 7'h00);
      check("chat_Fault", j, ifa.Fault, (FEAT && j >= 32 && j < 40) ? m_i7 : 7'h00);
      @(negedge ck);
    end
    ifa.FaultClr = 1'b0;
  endtask

  task automatic run_async();
    ifa.Raw = 7'h0F;
    for (int j = 0; j < 7; j++) begin
      @(posedge ck);
      #1;
      check("pre_I", j, ifa.I, (j >= 5) ? 7'h0F : 7'h00);
      @(negedge ck);
    end
    ifa.Raw = 7'h7F;
    repeat (4) @(negedge ck);
    clr_a = 1'b1;
    #1;
    check("async_I", 0, ifa.I, 7'h00);
    check("async_Chg", 0, ifa.Chg, 7'h00);
    check("async_Fault", 0, ifa.Fault, 7'h00);
    check("async_Tick", 0, {6'd0, ifa.Tick}, 7'h00);
    @(negedge ck);
    clr_a = 1'b0;
    for (int j = 0; j < 7; j++) begin
      @(posedge ck);
      #1;
      check("post_I", j, ifa.I, (j >= 5) ? 7'h7F : 7'h00);
      check("post_Chg", j, ifa.Chg, (j == 5) ? 7'h7F : 7'h00);
      @(negedge ck);
    end
  endtask

  // PRESC=8 instance: with hold, En is low for edges 10..29, shifting acceptance from 31 to 51.
  task automatic run_b(input bit hold);
    int acc;
    logic en;
    logic exp_t;
    acc = hold ? 51 : 31;
    @(negedge ck);
    clr_b = 1'b1; ifb.En = 1'b1; ifb.Raw = 7'h00; ifb.FaultClr = 1'b0;
    @(negedge ck);
    clr_b = 1'b0;
    ifb.Raw = m_i3;
    for (int j = 0; j < 56; j++) begin
      en = !(hold && j >= 10 && j < 30);
      ifb.En = en;
      @(posedge ck);
      #1;
      exp_t = en && (((hold && j >= 30) ? j - 20 : j) % 8 == 6);
      check(hold ? "hold_Tick" : "b_Tick", j, {6'd0, ifb.Tick}, {6'd0, exp_t});
      check(hold ? "hold_I" : "b_I", j, ifb.I, (j >= acc) ? m_i3 : 7'h00);
      check(hold ? "hold_Chg" : "b_Chg", j, ifb.Chg, (j == acc) ? m_i3 : 7'h00);
      @(negedge ck);
    end
  endtask

  initial begin
    nvec  = 0;
    nfail = 0;
    m_i3  = 7'h01 << CH_I3;
    m_i7  = 7'h01 << CH_I7;
    clr_a = 1'b1; clr_b = 1'b1;
    ifa.En = 1'b0; ifa.Raw = 7'h00; ifa.FaultClr = 1'b0;
    ifb.En = 1'b0; ifb.Raw = 7'h00; ifb.FaultClr = 1'b0;

    //  n clr en raw    I      Chg    Tick
    add(1, 1, 1, 7'h00, 7'h00, 7'h00, 0);
    add(5, 0, 1, 7'h7F, 7'h00, 7'h00, 1);
    add(1, 0, 1, 7'h7F, 7'h7F, 7'h7F, 1);
    add(1, 0, 1, 7'h7F, 7'h7F, 7'h00, 1);
    add(2, 1, 1, 7'h7F, 7'h00, 7'h00, 0);
    add(5, 0, 1, 7'h7F, 7'h00, 7'h00, 1);
    add(1, 0, 1, 7'h7F, 7'h7F, 7'h7F, 1);
    add(5, 0, 1, 7'h7E, 7'h7F, 7'h00, 1);
    add(1, 0, 1, 7'h7E, 7'h7E, 7'h01, 1);
    add(3, 0, 1, 7'h7F, 7'h7E, 7'h00, 1);
    add(4, 0, 1, 7'h7E, 7'h7E, 7'h00, 1);
    add(4, 0, 1, 7'h7F, 7'h7E, 7'h00, 1);
    add(1, 0, 1, 7'h7E, 7'h7E, 7'h00, 1);
    add(1, 0, 1, 7'h7E, 7'h7F, 7'h01, 1);
    add(3, 0, 1, 7'h7E, 7'h7F, 7'h00, 1);
    add(1, 0, 1, 7'h7E, 7'h7E, 7'h01, 1);
    add(1, 0, 1, 7'h7E, 7'h7E, 7'h00, 1);
    add(1, 1, 1, 7'h00, 7'h00, 7'h00, 0);
    add(5, 0, 1, 7'h55, 7'h00, 7'h00, 1);
    add(1, 0, 1, 7'h55, 7'h55, 7'h55, 1);
    add(5, 0, 1, 7'h2A, 7'h55, 7'h00, 1);
    add(1, 0, 1, 7'h2A, 7'h2A, 7'h7F, 1);
    add(3, 0, 1, 7'h00, 7'h2A, 7'h00, 1);
    add(2, 0, 0, 7'h00, 7'h2A, 7'h00, 0);
    add(2, 0, 1, 7'h00, 7'h2A, 7'h00, 1);
    add(1, 0, 1, 7'h00, 7'h00, 7'h2A, 1);
    add(1, 0, 1, 7'h00, 7'h00, 7'h00, 1);

    run_table();
    run_chatter();
    run_async();
    run_b(1'b0);
    run_b(1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
